// File: rtl/cache_fill_arbiter_if.sv
// rtl/cache_fill_arbiter_if.sv - cache request, SRAM and fill-return bundle for cache_fill_arbiter
// Purpose: groups both cache request ports, the SRAM port and the shared
//          fill-return port into one bundle.
// Modports:
//   slave  - the arbiter: takes requests and SRAM read data, drives SRAM
//            controls, the fill-return port and busy.
//   master - the caches and SRAM side facing the arbiter.
// Signals:
//   i_req/i_addr                   icache fill request
//   d_req/d_wr/d_addr/d_wdata      dcache fill or single-word write request
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata   single-ported SRAM
//   rdata/rword/i_rvalid/d_rvalid  returned fill words
//   i_done/d_done                  completion pulses
//   busy                           arbiter not idle
interface cache_fill_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] rdata;
  logic [2:0]  rword;
  logic        i_rvalid;
  logic        d_rvalid;
  logic        i_done;
  logic        d_done;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, rdata, rword,
           i_rvalid, d_rvalid, i_done, d_done, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, rdata, rword,
           i_rvalid, d_rvalid, i_done, d_done, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - round-robin icache/dcache fill and write arbiter onto one SRAM
// Purpose: accepts block fills from both caches and single-word writes from
//          the dcache, serves them one at a time on a single-ported SRAM, and
//          returns fill words through a LATENCY-deep return pipeline.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    cache_fill_arbiter_if.slave (requests, SRAM, fill return, busy)
// Parameters:
//   LATENCY  cycles from SRAM address issue to word delivery (>= 1)
module cache_fill_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_fill_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic        port_q, port_d;        // 1 = dcache owns the transaction
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        last_d_q, last_d_d;    // 1 = dcache was served most recently

  // Return pipeline. Stage 0 is the cycle the SRAM presents read data, so
  // its data comes straight from mem_rdata; pd_q[0] therefore stays zero.
  logic        pv_q [LATENCY];
  logic        pv_d [LATENCY];
  logic        pw_q [LATENCY];
  logic        pw_d [LATENCY];
  logic [2:0]  pk_q [LATENCY];
  logic [2:0]  pk_d [LATENCY];
  logic [15:0] pd_q [LATENCY];
  logic [15:0] pd_d [LATENCY];

  logic        out_v;
  logic        out_wr;
  logic [2:0]  out_k;
  logic [15:0] out_data;
  logic        out_rvalid;
  logic        done_now;
  logic        pick_d;

  always_comb begin
    out_v    = pv_q[LATENCY-1];
    out_wr   = pw_q[LATENCY-1];
    out_k    = pk_q[LATENCY-1];
    out_data = (LATENCY == 1) ? bus.mem_rdata : pd_q[LATENCY-1];
    // Writes travel as data-less tags: they end the transaction but never
    // present a word.
    out_rvalid = out_v && !out_wr;
    done_now   = out_v && (out_wr || (out_k == 3'd7));
  end

  always_comb begin
    pv_d[0] = (state_q == ISSUE);
    pw_d[0] = wr_q;
    pk_d[0] = k_q;
    pd_d[0] = '0;
    for (int s = 1; s < LATENCY; s++) begin
      pv_d[s] = pv_q[s-1];
      pw_d[s] = pw_q[s-1];
      pk_d[s] = pk_q[s-1];
      pd_d[s] = (s == 1) ? bus.mem_rdata : pd_q[s-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    port_d    = port_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_d_d  = last_d_q;
    pick_d    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // On contention the port not served last wins.
          pick_d   = bus.d_req && (!bus.i_req || !last_d_q);
          port_d   = pick_d;
          last_d_d = pick_d;
          wr_d     = pick_d && bus.d_wr;
          addr_d   = pick_d ? bus.d_addr : bus.i_addr;
          wdata_d  = pick_d ? bus.d_wdata : '0;
          k_d      = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_wr = wr_q;
        if (wr_q) begin
          bus.mem_addr  = addr_q & 16'hFFFE;
          bus.mem_wdata = wdata_q;
          state_d       = DRAIN;
        end else begin
          bus.mem_addr = {addr_q[15:4], k_q, 1'b0};
          k_d          = k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (done_now) begin
          bus.i_done = !port_q;
          bus.d_done = port_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Requests are ignored here so a cache can drop req after done.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.i_rvalid = out_rvalid && !port_q;
    bus.d_rvalid = out_rvalid && port_q;
    bus.rdata    = out_rvalid ? out_data : '0;
    bus.rword    = out_rvalid ? out_k : '0;
    bus.busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      port_q   <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_d_q <= 1'b0;
      for (int s = 0; s < LATENCY; s++) begin
        pv_q[s] <= 1'b0;
        pw_q[s] <= 1'b0;
        pk_q[s] <= '0;
        pd_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      port_q   <= port_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_d_q <= last_d_d;
      for (int s = 0; s < LATENCY; s++) begin
        pv_q[s] <= pv_d[s];
        pw_q[s] <= pw_d[s];
        pk_q[s] <= pk_d[s];
        pd_q[s] <= pd_d[s];
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - self-checking bench for cache_fill_arbiter
module tb_cache_fill_arbiter;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_fill_arbiter_if bus();

  cache_fill_arbiter #(.LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input logic [14:0] w);
    return {w[7:0], ~w[14:7]} ^ 16'h3C5A;
  endfunction

  // SRAM model: unwritten words read back as pat(word index).
  logic [15:0] sram    [32768];
  bit          written [32768];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) begin
        sram[bus.mem_addr[15:1]]    <= bus.mem_wdata;
        written[bus.mem_addr[15:1]] <= 1'b1;
      end else begin
        bus.mem_rdata <= written[bus.mem_addr[15:1]] ? sram[bus.mem_addr[15:1]]
                                                     : pat(bus.mem_addr[15:1]);
      end
    end
  end

  // Bench-side memory contents, updated only from issued stimulus.
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(input logic [14:0] w);
    if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
    return pat(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    logic        port_d;
    int          at;
    logic [2:0]  k;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic void push_fill(input logic port_d, input logic [15:0] addr, input int first_at, input int nwords);
    exp_t e;
    for (int k = 0; k < nwords; k++) begin
      e.port_d = port_d;
      e.at     = first_at + k;
      e.k      = 3'(k);
      e.data   = ref_rd({addr[15:4], 3'(k)});
      sb.push_back(e);
    end
  endfunction

  // Scoreboard monitor: every returned word must be the next expected one.
  exp_t mon_e;
  always @(negedge clk) begin
    chk("rvalid_onehot", 32'(bus.i_rvalid & bus.d_rvalid), 32'd0);
    if (bus.i_rvalid || bus.d_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: actual=rword %0d rdata %0h required=no word (cycle %0d)",
                 bus.rword, bus.rdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid_port", 32'(bus.d_rvalid), 32'(mon_e.port_d));
        chk("rword", 32'(bus.rword), 32'(mon_e.k));
        chk("rdata", 32'(bus.rdata), 32'(mon_e.data));
        chk("rvalid_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  typedef struct {
    logic        port_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          drop_rel;
    int          hold_extra;
    logic [15:0] first_addr;
    int          done_rel;
  } vec_t;
  vec_t vec [7];

  task automatic run_txn(input vec_t v);
    int t0;
    int done_at;
    int done_cnt;
    logic is_fill;
    logic exp_en;
    is_fill = !(v.port_d && v.wr);
    @(negedge clk);
    chk("idle_before", 32'(bus.busy), 32'd0);
    if (v.port_d) begin
      bus.d_req = 1'b1; bus.d_wr = v.wr; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr; bus.d_wr = v.wr;
    end
    t0 = cyc;
    done_at = -1;
    done_cnt = 0;
    if (is_fill) push_fill(v.port_d, v.addr, t0 + 1 + L, 8);
    else ref_mem[int'(v.addr[15:1])] = v.wdata;
    for (int rel = 1; rel <= v.done_rel + 3; rel++) begin
      @(negedge clk);
      exp_en = is_fill ? (rel <= 8) : (rel == 1);
      chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
      if (exp_en) begin
        chk("mem_wr", 32'(bus.mem_wr), 32'(!is_fill));
        chk("mem_addr", 32'(bus.mem_addr), 32'(v.first_addr + 16'(2 * (rel - 1))));
        if (!is_fill) chk("mem_wdata", 32'(bus.mem_wdata), 32'(v.wdata));
      end
      chk("other_done", 32'(v.port_d ? bus.i_done : bus.d_done), 32'd0);
      if (v.port_d ? bus.d_done : bus.i_done) begin
        done_at = rel;
        done_cnt++;
      end
      if (rel == v.done_rel + 1) chk("busy_hold", 32'(bus.busy), 32'd1);
      if (rel >= v.done_rel + 2) chk("busy_idle", 32'(bus.busy), 32'd0);
      if (rel == v.drop_rel || rel == v.done_rel + v.hold_extra) begin
        if (v.port_d) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
      end
    end
    chk("done_cycle", 32'(done_at), 32'(v.done_rel));
    chk("done_count", 32'(done_cnt), 32'd1);
  endtask

  task automatic run_pair(input logic d_first, input logic [15:0] ia, input logic [15:0] da);
    int t0;
    int i_done_at;
    int d_done_at;
    @(negedge clk);
    chk("pair_idle_before", 32'(bus.busy), 32'd0);
    bus.i_req = 1'b1; bus.i_addr = ia;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = da;
    t0 = cyc;
    i_done_at = -1;
    d_done_at = -1;
    push_fill(d_first, d_first ? da : ia, t0 + 1 + L, 8);
    push_fill(!d_first, d_first ? ia : da, t0 + 11 + 2 * L, 8);
    for (int rel = 1; rel <= 21 + 2 * L; rel++) begin
      @(negedge clk);
      if (rel == 1)
        chk("pair_first_addr", 32'(bus.mem_addr), 32'({d_first ? da[15:4] : ia[15:4], 4'h0}));
      if (rel == 11 + L)
        chk("pair_second_addr", 32'(bus.mem_addr), 32'({d_first ? ia[15:4] : da[15:4], 4'h0}));
      if (bus.i_done) begin i_done_at = rel; bus.i_req = 1'b0; end
      if (bus.d_done) begin d_done_at = rel; bus.d_req = 1'b0; end
    end
    chk("pair_i_done", 32'(i_done_at), 32'(d_first ? 18 + 2 * L : 8 + L));
    chk("pair_d_done", 32'(d_done_at), 32'(d_first ? 8 + L : 18 + 2 * L));
    chk("pair_idle_after", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"},    32'(bus.mem_en),    32'd0);
    chk({tag, "_mem_wr"},    32'(bus.mem_wr),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_rdata"},     32'(bus.rdata),     32'd0);
    chk({tag, "_rword"},     32'(bus.rword),     32'd0);
    chk({tag, "_i_rvalid"},  32'(bus.i_rvalid),  32'd0);
    chk({tag, "_d_rvalid"},  32'(bus.d_rvalid),  32'd0);
    chk({tag, "_i_done"},    32'(bus.i_done),    32'd0);
    chk({tag, "_d_done"},    32'(bus.d_done),    32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  initial begin
    int t0;
    int dcnt;
    vec[0] = '{1'b0, 1'b0, 16'h1236, 16'h0000, -1, 0, 16'h1230, 8 + L};
    vec[1] = '{1'b1, 1'b1, 16'h00A5, 16'hBEEF, -1, 0, 16'h00A4, 1 + L};
    vec[2] = '{1'b1, 1'b0, 16'h00A0, 16'h0000, -1, 0, 16'h00A0, 8 + L};
    vec[3] = '{1'b0, 1'b1, 16'h00A8, 16'h0000, -1, 0, 16'h00A0, 8 + L};
    vec[4] = '{1'b1, 1'b1, 16'h0100, 16'h1234, -1, 2, 16'h0100, 1 + L};
    vec[5] = '{1'b0, 1'b0, 16'hFFF0, 16'h0000,  3, 0, 16'hFFF0, 8 + L};
    vec[6] = '{1'b1, 1'b0, 16'h010E, 16'h0000, -1, 0, 16'h0100, 8 + L};

    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    run_pair(1'b1, 16'h2220, 16'h3330);
    run_pair(1'b1, 16'h2240, 16'h3340);

    for (int i = 0; i < 7; i++) run_txn(vec[i]);

    run_pair(1'b0, 16'h5550, 16'h6660);

    // Reset in the middle of a fill: words 0 and 1 are out before the reset
    // edge, nothing afterwards.
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 16'h4440;
    t0 = cyc;
    dcnt = 0;
    push_fill(1'b0, 16'h4440, t0 + 1 + L, 2);
    for (int rel = 1; rel <= 20; rel++) begin
      @(negedge clk);
      if (rel >= 7 && (bus.i_done || bus.d_done)) dcnt++;
      if (rel == 6) begin
        rst_n = 1'b0;
        bus.i_req = 1'b0;
      end
      if (rel == 7) begin
        rst_n = 1'b1;
        chk("midreset_busy", 32'(bus.busy), 32'd0);
      end
      if (rel >= 7) chk("midreset_mem_en", 32'(bus.mem_en), 32'd0);
    end
    chk("midreset_no_done", 32'(dcnt), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
